// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// hazard_scoreboard_pkg: forward-select encodings and branch_d bit positions
// shared by the hazard controller and its scoreboard.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int BR_RS_RT   = 0;
  localparam int BR_RS_ONLY = 1;

  // The younger producer in M takes priority over the older one in W.
  function automatic fwd_sel_e fwd_select(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_M;
    if (hit_w) return FWD_W;
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_ll_scoreboard.sv
`default_nettype none
// ll_scoreboard: per-register pending-write bits and owning unit for
// long-latency producers, with set/clear/kill and source busy lookup.
module ll_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5,
  parameter int N_LL    = 2,
  parameter int LL_IDW  = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   set_i,
  input  logic [REG_AW-1:0]      set_reg_i,
  input  logic [LL_IDW-1:0]      set_id_i,
  input  logic [N_LL-1:0]        done_i,
  input  logic [N_LL*REG_AW-1:0] done_reg_i,
  input  logic                   kill_i,
  input  logic [REG_AW-1:0]      rs_i,
  input  logic [REG_AW-1:0]      rt_i,
  input  logic [REG_AW-1:0]      dst_i,
  output logic                   rs_busy_o,
  output logic                   rt_busy_o,
  output logic                   dst_busy_o,
  output logic [REG_NUM-1:0]     busy_vec_o
);

  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [LL_IDW-1:0]  owner_q [REG_NUM];
  logic [LL_IDW-1:0]  owner_d [REG_NUM];

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    // A completion only retires the entry if that unit still owns it.
    for (int i = 0; i < N_LL; i++) begin
      if (done_i[i] && (owner_q[done_reg_i[i*REG_AW +: REG_AW]] == LL_IDW'(i))) begin
        busy_d[done_reg_i[i*REG_AW +: REG_AW]] = 1'b0;
      end
    end
    // Issue is applied after completion so a same-cycle reissue stays pending.
    if (set_i && (set_reg_i != '0)) begin
      busy_d[set_reg_i]  = 1'b1;
      owner_d[set_reg_i] = set_id_i;
    end
    if (kill_i) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
      for (int r = 0; r < REG_NUM; r++) begin
        owner_q[r] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign rs_busy_o  = busy_q[rs_i];
  assign rt_busy_o  = busy_q[rt_i];
  assign dst_busy_o = busy_q[dst_i];
  assign busy_vec_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// hazard_scoreboard: stall/flush/forward control for the 5-stage core, with a
// long-latency pending-write scoreboard and a sticky stall watchdog.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5,
  parameter int N_LL    = 2,
  parameter int LL_IDW  = 1,
  parameter int WD_W    = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [REG_AW-1:0]      rs_d,
  input  logic [REG_AW-1:0]      rt_d,
  input  logic                   use_rs_d,
  input  logic                   use_rt_d,
  input  logic [REG_AW-1:0]      dst_d,
  input  logic                   ll_d,
  input  logic [LL_IDW-1:0]      ll_id_d,
  input  logic [1:0]             branch_d,
  input  logic                   jump_src_d,
  input  logic [REG_AW-1:0]      rs_e,
  input  logic [REG_AW-1:0]      rt_e,
  input  logic                   reg_write_e,
  input  logic                   reg_write_m,
  input  logic                   reg_write_w,
  input  logic [REG_AW-1:0]      write_reg_e,
  input  logic [REG_AW-1:0]      write_reg_m,
  input  logic [REG_AW-1:0]      write_reg_w,
  input  logic                   mem_read_e,
  input  logic                   mem_read_m,
  input  logic                   mdu_ready_e,
  input  logic [N_LL-1:0]        ll_done,
  input  logic [N_LL*REG_AW-1:0] ll_done_reg,
  input  logic                   except_m,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   stall_e,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic                   flush_m,
  output logic                   flush_w,
  output logic [1:0]             forward_ae,
  output logic [1:0]             forward_be,
  output logic                   forward_ad,
  output logic                   forward_bd,
  output logic                   ll_kill,
  output logic [REG_NUM-1:0]     busy_vec,
  output logic                   hazard_timeout
);

  logic rs_used, rt_used;
  logic rs_pend, rt_pend;
  logic cmp_rs, cmp_rt;
  logic load_stall, branch_stall, jump_stall, sb_stall, any_stall;
  logic rs_busy, rt_busy, dst_busy;
  logic sb_set;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  // Register 0 is hardwired, so a read of it can never be a hazard.
  assign rs_used = use_rs_d & (rs_d != '0);
  assign rt_used = use_rt_d & (rt_d != '0);

  // Source still being produced by an E-stage ALU op or an M-stage load.
  assign rs_pend = (reg_write_e & (write_reg_e == rs_d)) | (mem_read_m & (write_reg_m == rs_d));
  assign rt_pend = (reg_write_e & (write_reg_e == rt_d)) | (mem_read_m & (write_reg_m == rt_d));

  assign cmp_rs = rs_used & (branch_d[BR_RS_ONLY] | branch_d[BR_RS_RT]);
  assign cmp_rt = rt_used & branch_d[BR_RS_RT];

  assign load_stall = mem_read_e & (write_reg_e != '0) &
                      ((rs_used & (rs_d == write_reg_e)) | (rt_used & (rt_d == write_reg_e)));
  assign branch_stall = (cmp_rs & rs_pend) | (cmp_rt & rt_pend);
  assign jump_stall   = jump_src_d & rs_used & rs_pend;
  assign sb_stall     = (rs_used & rs_busy) | (rt_used & rt_busy) | (ll_d & dst_busy);
  assign any_stall    = load_stall | branch_stall | jump_stall | sb_stall;

  assign stall_f = ~except_m & (any_stall | ~mdu_ready_e);
  assign stall_d = stall_f;
  assign stall_e = ~mdu_ready_e;
  assign flush_e = except_m | any_stall;
  assign flush_d = except_m;
  assign flush_m = except_m;
  assign flush_w = except_m;
  assign ll_kill = except_m;

  assign forward_ae = fwd_select(reg_write_m & (write_reg_m != '0) & (write_reg_m == rs_e),
                                 reg_write_w & (write_reg_w != '0) & (write_reg_w == rs_e));
  assign forward_be = fwd_select(reg_write_m & (write_reg_m != '0) & (write_reg_m == rt_e),
                                 reg_write_w & (write_reg_w != '0) & (write_reg_w == rt_e));
  assign forward_ad = reg_write_m & (write_reg_m != '0) & (write_reg_m == rs_d);
  assign forward_bd = reg_write_m & (write_reg_m != '0) & (write_reg_m == rt_d);

  assign sb_set = ll_d & ~stall_d & ~except_m;

  ll_scoreboard #(
    .REG_NUM (REG_NUM),
    .REG_AW  (REG_AW),
    .N_LL    (N_LL),
    .LL_IDW  (LL_IDW)
  ) u_ll_scoreboard (
    .clk        (clk),
    .resetn     (resetn),
    .set_i      (sb_set),
    .set_reg_i  (dst_d),
    .set_id_i   (ll_id_d),
    .done_i     (ll_done),
    .done_reg_i (ll_done_reg),
    .kill_i     (except_m),
    .rs_i       (rs_d),
    .rt_i       (rt_d),
    .dst_i      (dst_d),
    .rs_busy_o  (rs_busy),
    .rt_busy_o  (rt_busy),
    .dst_busy_o (dst_busy),
    .busy_vec_o (busy_vec)
  );

  always_comb begin
    wd_d = '0;
    if (stall_d) begin
      wd_d = (&wd_q) ? wd_q : wd_q + WD_W'(1);
    end
    timeout_d = timeout_q | (&wd_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign hazard_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked
// against a behavioural model of the hazard rules and scoreboard.
module tb_hazard_scoreboard;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int N_LL    = 2;
  localparam int LL_IDW  = 1;
  localparam int WD_W    = 8;

  logic clk = 1'b0;
  logic resetn;
  logic [4:0] rs_d, rt_d, dst_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic use_rs_d, use_rt_d, ll_d, jump_src_d;
  logic [0:0] ll_id_d;
  logic [1:0] branch_d;
  logic reg_write_e, reg_write_m, reg_write_w, mem_read_e, mem_read_m, mdu_ready_e, except_m;
  logic [1:0] ll_done;
  logic [9:0] ll_done_reg;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, flush_w;
  logic [1:0] forward_ae, forward_be;
  logic forward_ad, forward_bd, ll_kill, hazard_timeout;
  logic [31:0] busy_vec;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_NUM(REG_NUM), .REG_AW(REG_AW), .N_LL(N_LL), .LL_IDW(LL_IDW), .WD_W(WD_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .dst_d(dst_d), .ll_d(ll_d), .ll_id_d(ll_id_d), .branch_d(branch_d), .jump_src_d(jump_src_d),
    .rs_e(rs_e), .rt_e(rt_e),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .mem_read_e(mem_read_e), .mem_read_m(mem_read_m), .mdu_ready_e(mdu_ready_e),
    .ll_done(ll_done), .ll_done_reg(ll_done_reg), .except_m(except_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .ll_kill(ll_kill), .busy_vec(busy_vec), .hazard_timeout(hazard_timeout)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural model: pending set of registers with owners, and a run-length
  // count of consecutive stalled cycles.
  bit m_busy [REG_NUM];
  int m_owner[REG_NUM];
  int m_run;
  bit m_timeout;

  task automatic model_reset();
    for (int r = 0; r < REG_NUM; r++) begin
      m_busy[r]  = 1'b0;
      m_owner[r] = 0;
    end
    m_run     = 0;
    m_timeout = 1'b0;
  endtask

  function automatic bit reads(input logic u, input logic [4:0] r);
    return u && (r != 0);
  endfunction

  function automatic bit in_flight(input logic [4:0] r);
    return (reg_write_e && write_reg_e == r) || (mem_read_m && write_reg_m == r);
  endfunction

  function automatic bit m_any_stall();
    bit rs = reads(use_rs_d, rs_d);
    bit rt = reads(use_rt_d, rt_d);
    bit ld = mem_read_e && write_reg_e != 0 &&
             ((rs && rs_d == write_reg_e) || (rt && rt_d == write_reg_e));
    bit br = (rs && branch_d != 2'b00 && in_flight(rs_d)) || (rt && branch_d[0] && in_flight(rt_d));
    bit jp = jump_src_d && rs && in_flight(rs_d);
    bit sb = (rs && m_busy[rs_d]) || (rt && m_busy[rt_d]) || (ll_d && m_busy[dst_d]);
    return ld || br || jp || sb;
  endfunction

  function automatic bit m_stall();
    return !except_m && (m_any_stall() || !mdu_ready_e);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (reg_write_m && write_reg_m != 0 && write_reg_m == src) return 2'd2;
    if (reg_write_w && write_reg_w != 0 && write_reg_w == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [13:0] m_ctl();
    bit sd = m_stall();
    bit fad = reg_write_m && write_reg_m != 0 && write_reg_m == rs_d;
    bit fbd = reg_write_m && write_reg_m != 0 && write_reg_m == rt_d;
    return {sd, sd, !mdu_ready_e, except_m, except_m || m_any_stall(), except_m, except_m,
            except_m, m_fwd(rs_e), m_fwd(rt_e), fad, fbd};
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < REG_NUM; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_edge();
    bit sd = m_stall();
    if (except_m) begin
      for (int r = 0; r < REG_NUM; r++) m_busy[r] = 1'b0;
    end else begin
      for (int i = 0; i < N_LL; i++) begin
        int rr = int'(ll_done_reg[i*5 +: 5]);
        if (ll_done[i] && m_owner[rr] == i) m_busy[rr] = 1'b0;
      end
      if (ll_d && !sd && dst_d != 0) begin
        m_busy[dst_d]  = 1'b1;
        m_owner[dst_d] = int'(ll_id_d);
      end
    end
    m_run = sd ? ((m_run < 255) ? m_run + 1 : 255) : 0;
    if (m_run == 255) m_timeout = 1'b1;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rs_d, rt_d, dst_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {use_rs_d, use_rt_d, ll_d, jump_src_d, ll_id_d, branch_d} = '0;
    {reg_write_e, reg_write_m, reg_write_w, mem_read_e, mem_read_m, except_m} = '0;
    ll_done = '0;
    ll_done_reg = '0;
    mdu_ready_e = 1'b1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_ctl"}, {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, flush_w, ll_kill,
                        forward_ae, forward_be, forward_ad, forward_bd}, m_ctl());
    chk({tag, "_busy"}, busy_vec, m_busy_vec());
    chk({tag, "_timeout"}, hazard_timeout, m_timeout);
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, flush_w, ll_kill,
                          forward_ae, forward_be, forward_ad, forward_bd}, 14'd0);
    chk("reset_busy", busy_vec, 32'd0);
    chk("reset_timeout", hazard_timeout, 1'b0);
    resetn = 1'b1;
    cycle();

    // Load-use stall, and no stall when the source is not actually read.
    mem_read_e = 1; reg_write_e = 1; write_reg_e = 5'd2; rs_d = 5'd2; use_rs_d = 1;
    #1 chk("load_use_stall", {stall_f, stall_d, flush_e}, 3'b111);
    use_rs_d = 0;
    #1 chk("load_unused_src", {stall_f, stall_d, flush_e}, 3'b000);
    idle();

    // E-stage forwarding priority.
    rs_e = 5'd5; reg_write_m = 1; write_reg_m = 5'd5; reg_write_w = 1; write_reg_w = 5'd5;
    #1 chk("fwd_m_over_w", forward_ae, 2'b10);
    reg_write_m = 0;
    #1 chk("fwd_w_only", forward_ae, 2'b01);
    reg_write_m = 1; rs_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
    #1 chk("fwd_reg0", forward_ae, 2'b00);
    idle();
    cycle();

    // Long-latency issue to $8 by unit 1, consumer stalls until done.
    ll_d = 1; dst_d = 5'd8; ll_id_d = 1'b1;
    cycle();
    ll_d = 0; rs_d = 5'd8; use_rs_d = 1;
    #1 chk("ll_busy_set", busy_vec[8], 1'b1);
    chk("ll_consumer_stall", stall_d, 1'b1);
    cycle(); cycle();
    chk("ll_stall_held", stall_d, 1'b1);
    ll_done = 2'b10; ll_done_reg = {5'd8, 5'd0};
    #1 chk("ll_stall_done_cycle", stall_d, 1'b1);
    cycle();
    ll_done = '0;
    #1 chk("ll_busy_dropped", busy_vec[8], 1'b0);
    chk("ll_stall_released", stall_d, 1'b0);
    idle();

    // Non-owner completion is ignored; same-cycle issue beats completion.
    ll_d = 1; dst_d = 5'd8; ll_id_d = 1'b1;
    cycle();
    ll_d = 0; ll_done = 2'b01; ll_done_reg = {5'd0, 5'd8};
    cycle();
    ll_done = '0;
    #1 chk("non_owner_done", busy_vec[8], 1'b1);
    ll_d = 1; dst_d = 5'd9; ll_id_d = 1'b1; ll_done = 2'b01; ll_done_reg = {5'd0, 5'd9};
    cycle();
    idle();
    #1 chk("set_beats_clear", busy_vec[9], 1'b1);
    ll_done = 2'b01; ll_done_reg = {5'd0, 5'd9};
    cycle();
    #1 chk("owner_updated", busy_vec[9], 1'b1);
    ll_done = 2'b10; ll_done_reg = {5'd9, 5'd0};
    cycle();
    ll_done = '0;
    #1 chk("owner_clears", busy_vec[9], 1'b0);

    // Exception kills in-flight ops and overrides the stall.
    rs_d = 5'd8; use_rs_d = 1;
    #1 chk("pre_except_stall", stall_d, 1'b1);
    except_m = 1;
    #1 chk("except_ctl", {stall_f, stall_d, flush_d, flush_e, flush_m, flush_w, ll_kill}, 7'b0011111);
    cycle();
    except_m = 0;
    #1 chk("except_busy_clear", busy_vec, 32'd0);
    idle();

    // Watchdog: 255 consecutive stalled cycles set the sticky flag.
    ll_d = 1; dst_d = 5'd10; ll_id_d = 1'b0;
    cycle();
    ll_d = 0; rs_d = 5'd10; use_rs_d = 1;
    repeat (254) cycle();
    chk("wd_254", hazard_timeout, 1'b0);
    cycle();
    chk("wd_255", hazard_timeout, 1'b1);
    ll_done = 2'b01; ll_done_reg = {5'd0, 5'd10};
    cycle();
    ll_done = '0;
    cycle();
    chk("wd_sticky_stall", stall_d, 1'b0);
    chk("wd_sticky", hazard_timeout, 1'b1);
    idle();

    // Asynchronous reset mid-test.
    ll_d = 1; dst_d = 5'd3;
    cycle();
    idle();
    chk("pre_reset_busy", busy_vec[3], 1'b1);
    resetn = 0;
    model_reset();
    #1 chk("async_reset_busy", busy_vec, 32'd0);
    chk("async_reset_timeout", hazard_timeout, 1'b0);
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rs_d = 5'($urandom_range(0, 7)); rt_d = 5'($urandom_range(0, 7));
      dst_d = 5'($urandom_range(0, 7));
      use_rs_d = 1'($urandom); use_rt_d = 1'($urandom);
      ll_d = ($urandom_range(0, 2) == 0); ll_id_d = 1'($urandom);
      branch_d = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      jump_src_d = ($urandom_range(0, 7) == 0);
      rs_e = 5'($urandom_range(0, 7)); rt_e = 5'($urandom_range(0, 7));
      reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      write_reg_e = 5'($urandom_range(0, 7)); write_reg_m = 5'($urandom_range(0, 7));
      write_reg_w = 5'($urandom_range(0, 7));
      mem_read_e = ($urandom_range(0, 3) == 0); mem_read_m = ($urandom_range(0, 3) == 0);
      mdu_ready_e = ($urandom_range(0, 7) != 0);
      except_m = ($urandom_range(0, 19) == 0);
      ll_done[0] = ($urandom_range(0, 2) == 0); ll_done[1] = ($urandom_range(0, 2) == 0);
      ll_done_reg = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1 model_check("rnd");
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
